mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multi-cycle signed multiply/divide engine that sits beside the single-cycle ALU in the EX stage.
- The ALU's MUL/DIV paths are retired; this block takes those operations over.
- It accepts the same ALU control codes and operands from the issue side, then returns results through a start/busy/done handshake.
- The pipeline stalls on Busy_o.

Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- Start_i  in  1  request strobe; sampled only in IDLE
- ALUCtl_i  in  4  operation code; only `ALU_CTL_MUL and `ALU_CTL_DIV are accepted
- Op1_i  in  WIDTH  multiplicand / dividend, two's complement
- Op2_i  in  WIDTH  multiplier / divisor, two's complement
- Busy_o  out  1  high whenever state != IDLE
- Done_o  out  1  one-cycle pulse; results valid in that cycle
- Res_o  out  WIDTH  MUL: low half of product; DIV: quotient
- Rem_o  out  WIDTH  MUL: high half of product; DIV: remainder
- DivZero_o  out  1  DIV with Op2_i == 0; valid with Done_o, held until the next acceptance

Behaviour:
- Reset (rst_i low at a clock edge): state IDLE; Busy_o, Done_o, DivZero_o = 0; Res_o, Rem_o = 0; counter and datapath cleared.
  - Reset mid-operation aborts the operation. No Done_o is produced.
- States and transitions:
  - IDLE -> CALC on acceptance (Start_i=1 and a legal code).
  - CALC -> FIXUP after WIDTH iterations.
  - FIXUP -> DONE.
  - DONE -> IDLE.
- Acceptance:
  - Occurs only in IDLE with Start_i=1 and a legal ALUCtl_i.
  - Illegal codes are ignored: the block stays IDLE and asserts no output.
  - Start_i while Busy_o=1 (including the DONE cycle) is ignored.
- On the accepting edge, latch:
  - op kind;
  - |Op1|, |Op2|;
  - sign flags: MUL negate = s1^s2; DIV quotient negate = s1^s2, remainder negate = s1.
- MUL datapath:
  - Unsigned shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
  - FIXUP two's-complement negates the full 2*WIDTH product if flagged.
  - Res_o = product[WIDTH-1:0], Rem_o = product[2*WIDTH-1:WIDTH].
- DIV datapath:
  - Restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder.
  - FIXUP applies the sign flags. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Overflow case most-negative / -1: quotient = 0x80000000 (for WIDTH=32), remainder = 0, no flag.
- Divide by zero:
  - Accepting edge goes directly IDLE -> DONE.
  - Res_o = all ones, Rem_o = Op1_i unmodified, DivZero_o = 1.
- Latency (normal op, accepting edge = edge 0):
  - CALC covers edges 1..WIDTH.
  - FIXUP is entered at edge WIDTH; DONE at edge WIDTH+1.
  - Done_o is high for the single cycle after edge WIDTH+1 (33rd edge for WIDTH=32).
- Divide-by-zero latency: Done_o is high in the cycle after edge 0.
- Output timing:
  - Res_o, Rem_o, DivZero_o are registered, update only on the edge entering DONE, and hold until the next DONE or reset.
  - DivZero_o clears on the next acceptance.
- Counter: log2(WIDTH)+1 bits. No wrap is permitted; CALC exits exactly at count == WIDTH-1 after that iteration.

Decomposition:
- Const.v (shared): add state encodings MDU_IDLE/MDU_CALC/MDU_FIXUP/MDU_DONE (2-bit).
- Const.v reuses `ALU_CTL_MUL/`ALU_CTL_DIV; no new ALU codes.
- One natural sub-module: mdu_negate (parameterised-width two's-complement conditional negator), used for operand magnitudes and FIXUP.
- Everything else stays inline.

Test Plan:
- MUL 7 x -3 -> Done_o 33 edges after accept; Res_o=0xFFFFFFEB, Rem_o=0xFFFFFFFF, DivZero_o=0.
- MUL 0x40000000 x 4 -> Res_o=0x00000000, Rem_o=0x00000001.
- DIV -7 / 2 -> Res_o=0xFFFFFFFD (-3), Rem_o=0xFFFFFFFF (-1). Separately, DIV 0x80000000 / 0xFFFFFFFF -> Res_o=0x80000000, Rem_o=0.
- DIV 100 / 0 -> Done_o the cycle after accept; Res_o=0xFFFFFFFF, Rem_o=100, DivZero_o=1. A following MUL 2x3 -> DivZero_o=0 from acceptance, Res_o=6.
- Start_i held high continuously with alternating MUL/DIV -> new op accepted only in IDLE (one idle cycle after each Done_o); mid-op operand changes have no effect. ALUCtl_i=`ALU_CTL_ADD with Start_i -> Busy_o stays 0.
- rst_i low at iteration 10 of a DIV -> next cycle Busy_o=0, outputs 0, no Done_o. A subsequent MUL 5x5 -> Res_o=25.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned CTL_W = 4;

  localparam logic [CTL_W-1:0] ALU_CTL_ADD = 4'h2;
  localparam logic [CTL_W-1:0] ALU_CTL_MUL = 4'hA;
  localparam logic [CTL_W-1:0] ALU_CTL_DIV = 4'hB;

  localparam logic [1:0] MDU_IDLE  = 2'd0;
  localparam logic [1:0] MDU_CALC  = 2'd1;
  localparam logic [1:0] MDU_FIXUP = 2'd2;
  localparam logic [1:0] MDU_DONE  = 2'd3;

  typedef enum logic {
    MDU_OP_MUL = 1'b0,
    MDU_OP_DIV = 1'b1
  } mdu_op_e;

  // Operation latched at acceptance together with its result sign fixups.
  typedef struct packed {
    mdu_op_e op;
    logic    neg_res;
    logic    neg_rem;
  } mdu_ctl_t;

  function automatic logic mdu_ctl_legal(input logic [CTL_W-1:0] ctl);
    return (ctl == ALU_CTL_MUL) || (ctl == ALU_CTL_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue-side request and result handshake of the multiply/divide unit.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic             Start_i;
  logic [CTL_W-1:0] ALUCtl_i;
  logic [WIDTH-1:0] Op1_i;
  logic [WIDTH-1:0] Op2_i;
  logic             Busy_o;
  logic             Done_o;
  logic [WIDTH-1:0] Res_o;
  logic [WIDTH-1:0] Rem_o;
  logic             DivZero_o;

  modport master (
    output Start_i, ALUCtl_i, Op1_i, Op2_i,
    input  Busy_o, Done_o, Res_o, Rem_o, DivZero_o
  );

  modport slave (
    input  Start_i, ALUCtl_i, Op1_i, Op2_i,
    output Busy_o, Done_o, Res_o, Rem_o, DivZero_o
  );

endinterface

// File: rtl/mul_div_unit_negate.sv
// Conditional two's-complement negator used for magnitudes and sign fixup.
module mdu_negate #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val_c
);

  assign o_val_c = i_neg ? W'(~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) engine,
// one bit per cycle, with a start/busy/done handshake toward the EX stage.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned W2    = 2 * WIDTH;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  mdu_ctl_t         r_ctl;
  logic [W2-1:0]    r_acc;
  logic [WIDTH:0]   r_prem;
  logic [WIDTH-1:0] r_opb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic             w_accept;
  logic             w_is_div;
  logic             w_dz;
  logic             w_s1;
  logic             w_s2;
  logic             w_last;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_qbit;
  logic [W2-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_s1     = bus.Op1_i[WIDTH-1];
  assign w_s2     = bus.Op2_i[WIDTH-1];
  assign w_is_div = (bus.ALUCtl_i == ALU_CTL_DIV);
  assign w_dz     = w_is_div && (bus.Op2_i == '0);
  assign w_accept = (r_state == MDU_IDLE) && bus.Start_i && mdu_ctl_legal(bus.ALUCtl_i);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  mdu_negate #(.W(WIDTH)) u_abs1 (.i_val(bus.Op1_i), .i_neg(w_s1), .o_val_c(w_abs1));
  mdu_negate #(.W(WIDTH)) u_abs2 (.i_val(bus.Op2_i), .i_neg(w_s2), .o_val_c(w_abs2));

  // DIV keeps the quotient in r_acc's low half with a zero upper half,
  // so negating the full accumulator also yields the signed quotient.
  mdu_negate #(.W(W2)) u_neg_prod (.i_val(r_acc), .i_neg(r_ctl.neg_res), .o_val_c(w_prod_fix));
  mdu_negate #(.W(WIDTH)) u_neg_rem (.i_val(r_prem[WIDTH-1:0]), .i_neg(r_ctl.neg_rem),
                                     .o_val_c(w_rem_fix));

  // Shift-add step: multiplier sits in r_acc's low half and shifts out as the product forms.
  assign w_addend  = r_acc[0] ? r_opb : {WIDTH{1'b0}};
  assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, w_addend};

  // Restoring step: trial-subtract divisor from the shifted partial remainder.
  assign w_shift = {r_prem, r_acc[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, r_opb};
  assign w_qbit  = ~w_diff[WIDTH+1];

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= MDU_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MDU_IDLE:  if (w_accept) w_state_nxt = w_dz ? MDU_DONE : MDU_CALC;
      MDU_CALC:  if (w_last) w_state_nxt = MDU_FIXUP;
      MDU_FIXUP: w_state_nxt = MDU_DONE;
      MDU_DONE:  w_state_nxt = MDU_IDLE;
      default:   w_state_nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt  <= '0;
      r_ctl  <= '{op: MDU_OP_MUL, neg_res: 1'b0, neg_rem: 1'b0};
      r_acc  <= '0;
      r_prem <= '0;
      r_opb  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_res  <= '0;
      r_rem  <= '0;
      r_dz   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != MDU_IDLE);
      r_done <= (w_state_nxt == MDU_DONE);
      case (r_state)
        MDU_IDLE: begin
          if (w_accept) begin
            r_ctl  <= '{op:      w_is_div ? MDU_OP_DIV : MDU_OP_MUL,
                        neg_res: w_s1 ^ w_s2,
                        neg_rem: w_is_div & w_s1};
            r_cnt  <= '0;
            r_prem <= '0;
            r_acc  <= {{WIDTH{1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
            r_opb  <= w_is_div ? w_abs2 : w_abs1;
            r_dz   <= w_dz;
            if (w_dz) begin
              r_res <= '1;
              r_rem <= bus.Op1_i;
            end
          end
        end
        MDU_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_ctl.op == MDU_OP_MUL) begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end else begin
            r_acc  <= {r_acc[W2-1:WIDTH], r_acc[WIDTH-2:0], w_qbit};
            r_prem <= w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
          end
        end
        MDU_FIXUP: begin
          r_res <= w_prod_fix[WIDTH-1:0];
          r_rem <= (r_ctl.op == MDU_OP_MUL) ? w_prod_fix[W2-1:WIDTH] : w_rem_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy_o    = r_busy;
  assign bus.Done_o    = r_done;
  assign bus.Res_o     = r_res;
  assign bus.Rem_o     = r_rem;
  assign bus.DivZero_o = r_dz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, random ops against
// an arithmetic reference, and hand-written handshake/reset sequences.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] rem;
    logic        dz;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [31:0] rem,
                                output logic dz);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (ctl == ALU_CTL_MUL) begin
      p   = sa * sb;
      res = 32'(p);
      rem = 32'(p >>> 32);
    end else if (b == 32'd0) begin
      res = 32'hFFFF_FFFF;
      rem = a;
      dz  = 1'b1;
    end else begin
      res = 32'(sa / sb);
      rem = 32'(sa % sb);
    end
  endfunction

  // Called at a negedge; returns edges elapsed until Done_o is seen (60 = timeout).
  task automatic wait_done(output int k, input logic scramble);
    k = 0;
    while (!bus.Done_o && k < 60) begin
      if (scramble) begin
        bus.Op1_i    = $urandom;
        bus.Op2_i    = $urandom;
        bus.ALUCtl_i = 4'($urandom_range(0, 15));
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [31:0] rem,
                        output logic dz, output int k);
    bus.Start_i  = 1'b1;
    bus.ALUCtl_i = ctl;
    bus.Op1_i    = a;
    bus.Op2_i    = b;
    @(posedge clk);
    @(negedge clk);
    bus.Start_i = 1'b0;
    wait_done(k, 1'b1);
    res = bus.Res_o;
    rem = bus.Rem_o;
    dz  = bus.DivZero_o;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t        vecs[13];
  logic [31:0] g_res, g_rem, e_res, e_rem;
  logic        g_dz, e_dz, saw_done;
  logic [3:0]  ctl;
  logic [31:0] a, b;
  int          k;

  initial begin
    vecs[0]  = '{ALU_CTL_MUL, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 33};
    vecs[1]  = '{ALU_CTL_MUL, 32'h4000_0000, 32'd4,         32'h0000_0000, 32'h0000_0001, 1'b0, 33};
    vecs[2]  = '{ALU_CTL_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33};
    vecs[3]  = '{ALU_CTL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 33};
    vecs[4]  = '{ALU_CTL_DIV, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100,       1'b1, 0};
    vecs[5]  = '{ALU_CTL_MUL, 32'd2,         32'd3,         32'd6,         32'd0,         1'b0, 33};
    vecs[6]  = '{ALU_CTL_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 33};
    vecs[7]  = '{ALU_CTL_MUL, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0, 33};
    vecs[8]  = '{ALU_CTL_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 33};
    vecs[9]  = '{ALU_CTL_DIV, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0};
    vecs[10] = '{ALU_CTL_DIV, 32'd5,         32'd7,         32'd0,         32'd5,         1'b0, 33};
    vecs[11] = '{ALU_CTL_DIV, 32'hFFFF_FFFB, 32'd7,         32'd0,         32'hFFFF_FFFB, 1'b0, 33};
    vecs[12] = '{ALU_CTL_DIV, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 33};

    rst_n        = 1'b0;
    bus.Start_i  = 1'b0;
    bus.ALUCtl_i = ALU_CTL_ADD;
    bus.Op1_i    = '0;
    bus.Op2_i    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(bus.Busy_o), 64'd0);
    chk("reset_done", 64'(bus.Done_o), 64'd0);
    chk("reset_res",  64'(bus.Res_o),  64'd0);
    chk("reset_rem",  64'(bus.Rem_o),  64'd0);
    chk("reset_dz",   64'(bus.DivZero_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].ctl, vecs[i].a, vecs[i].b, g_res, g_rem, g_dz, k);
      chk($sformatf("vec%0d_res", i), 64'(g_res), 64'(vecs[i].res));
      chk($sformatf("vec%0d_rem", i), 64'(g_rem), 64'(vecs[i].rem));
      chk($sformatf("vec%0d_dz",  i), 64'(g_dz),  64'(vecs[i].dz));
      chk($sformatf("vec%0d_lat", i), 64'(k),     64'(vecs[i].lat));
    end

    for (int i = 0; i < 24; i++) begin
      ctl = $urandom_range(0, 1) ? ALU_CTL_DIV : ALU_CTL_MUL;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      if ($urandom_range(0, 1) == 1) b = -b;
      model(ctl, a, b, e_res, e_rem, e_dz);
      run_op(ctl, a, b, g_res, g_rem, g_dz, k);
      chk($sformatf("rnd%0d_res", i), 64'(g_res), 64'(e_res));
      chk($sformatf("rnd%0d_rem", i), 64'(g_rem), 64'(e_rem));
      chk($sformatf("rnd%0d_dz",  i), 64'(g_dz),  64'(e_dz));
      chk($sformatf("rnd%0d_lat", i), 64'(k),     e_dz ? 64'd0 : 64'd33);
    end

    // Divide-by-zero flag holds in IDLE and clears on the next acceptance.
    run_op(ALU_CTL_DIV, 32'd100, 32'd0, g_res, g_rem, g_dz, k);
    chk("dz_hold", 64'(bus.DivZero_o), 64'd1);
    bus.Start_i  = 1'b1;
    bus.ALUCtl_i = ALU_CTL_MUL;
    bus.Op1_i    = 32'd2;
    bus.Op2_i    = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.Start_i = 1'b0;
    chk("dz_clear_on_accept", 64'(bus.DivZero_o), 64'd0);
    chk("busy_after_accept",  64'(bus.Busy_o),    64'd1);
    wait_done(k, 1'b1);
    chk("after_dz_mul_res", 64'(bus.Res_o), 64'd6);
    @(posedge clk);
    @(negedge clk);

    // Start held high throughout: next op is taken only after one idle cycle.
    bus.Start_i  = 1'b1;
    bus.ALUCtl_i = ALU_CTL_MUL;
    bus.Op1_i    = 32'd9;
    bus.Op2_i    = 32'hFFFF_FFFC;
    @(posedge clk);
    @(negedge clk);
    bus.ALUCtl_i = ALU_CTL_DIV;
    bus.Op1_i    = 32'hFFFF_FF9C;
    bus.Op2_i    = 32'd7;
    wait_done(k, 1'b0);
    chk("cont_mul_lat", 64'(k),         64'd33);
    chk("cont_mul_res", 64'(bus.Res_o), 64'hFFFF_FFDC);
    chk("cont_mul_rem", 64'(bus.Rem_o), 64'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    chk("cont_idle_gap", 64'(bus.Busy_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("cont_reaccept", 64'(bus.Busy_o), 64'd1);
    bus.Start_i = 1'b0;
    wait_done(k, 1'b0);
    chk("cont_div_lat", 64'(k),         64'd33);
    chk("cont_div_res", 64'(bus.Res_o), 64'hFFFF_FFF2);
    chk("cont_div_rem", 64'(bus.Rem_o), 64'hFFFF_FFFE);
    @(posedge clk);
    @(negedge clk);

    // Illegal control code is never accepted.
    bus.Start_i  = 1'b1;
    bus.ALUCtl_i = ALU_CTL_ADD;
    saw_done     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      saw_done = saw_done | bus.Busy_o | bus.Done_o;
    end
    chk("illegal_ignored", 64'(saw_done), 64'd0);
    bus.Start_i = 1'b0;

    // Synchronous reset at iteration 10 of a DIV aborts it without Done.
    bus.Start_i  = 1'b1;
    bus.ALUCtl_i = ALU_CTL_DIV;
    bus.Op1_i    = 32'd1000;
    bus.Op2_i    = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.Start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", 64'(bus.Busy_o), 64'd0);
    chk("midrst_res",  64'(bus.Res_o),  64'd0);
    chk("midrst_rem",  64'(bus.Rem_o),  64'd0);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      saw_done = saw_done | bus.Done_o;
    end
    chk("midrst_no_done", 64'(saw_done), 64'd0);
    run_op(ALU_CTL_MUL, 32'd5, 32'd5, g_res, g_rem, g_dz, k);
    chk("post_rst_mul_res", 64'(g_res), 64'd25);
    chk("post_rst_mul_lat", 64'(k),     64'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
